// File: rtl/cache_pkg.sv
// Shared definitions for the 2-way write-back data cache: controller states,
// line width and the helper that picks one 32-bit word out of a line.
package cache_pkg;

  localparam int LINE_W = 128;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WB    = 2'd1,
    ALLOC = 2'd2
  } state_e;

  // Word w of a line occupies bits [32*w+31 : 32*w].
  function automatic logic [31:0] word_sel(input logic [LINE_W-1:0] line,
                                           input logic [1:0]        w);
    return line[{w, 5'b00000} +: 32];
  endfunction

endpackage

// File: rtl/dcache_way.sv
// One way of the cache: valid/dirty flags, tags and 128-bit lines for SETS
// entries. Reads are combinational at idx_i; all writes share idx_i.
module dcache_way
  import cache_pkg::*;
#(
  parameter int SETS    = 4,
  parameter int INDEX_W = 2,
  parameter int TAG_W   = 26
) (
  input  logic               clk,
  input  logic               rst_i,
  input  logic [INDEX_W-1:0] idx_i,
  input  logic               fill_i,
  input  logic [TAG_W-1:0]   fill_tag_i,
  input  logic [LINE_W-1:0]  fill_data_i,
  input  logic               word_we_i,
  input  logic [1:0]         word_i,
  input  logic [31:0]        word_data_i,
  input  logic               clean_i,
  output logic               valid_o,
  output logic               dirty_o,
  output logic [TAG_W-1:0]   tag_o,
  output logic [LINE_W-1:0]  data_o
);

  logic [SETS-1:0]   valid_q;
  logic [SETS-1:0]   dirty_q;
  logic [TAG_W-1:0]  tag_q  [SETS];
  logic [LINE_W-1:0] data_q [SETS];

  // Status flags: a refill makes the line valid and clean, a word write dirties it.
  always_ff @(posedge clk) begin
    if (rst_i) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else if (fill_i) begin
      valid_q[idx_i] <= 1'b1;
      dirty_q[idx_i] <= 1'b0;
    end else if (word_we_i) begin
      dirty_q[idx_i] <= 1'b1;
    end else if (clean_i) begin
      dirty_q[idx_i] <= 1'b0;
    end
  end

  // Tag and data storage are deliberately left unreset; valid gates their use.
  always_ff @(posedge clk) begin
    if (fill_i) begin
      tag_q[idx_i]  <= fill_tag_i;
      data_q[idx_i] <= fill_data_i;
    end else if (word_we_i) begin
      data_q[idx_i][{word_i, 5'b00000} +: 32] <= word_data_i;
    end
  end

  assign valid_o = valid_q[idx_i];
  assign dirty_o = dirty_q[idx_i];
  assign tag_o   = tag_q[idx_i];
  assign data_o  = data_q[idx_i];

endmodule

// File: rtl/dcache_2way_wb.sv
// 2-way set-associative write-back, write-allocate data cache with one LRU
// bit per set. Optional hit/miss counters when DCACHE_STATS_EN is defined.
module dcache_2way_wb
  import cache_pkg::*;
#(
  parameter int ADDR_W = 30,
  parameter int SETS   = 4
) (
  input  logic              clk,
  input  logic              proc_reset,
  input  logic              proc_read,
  input  logic              proc_write,
  input  logic [ADDR_W-1:0] proc_addr,
  input  logic [31:0]       proc_wdata,
  output logic              proc_stall,
  output logic [31:0]       proc_rdata,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-3:0] mem_addr,
  output logic [LINE_W-1:0] mem_wdata,
  input  logic [LINE_W-1:0] mem_rdata,
`ifdef DCACHE_STATS_EN
  output logic [31:0]       hit_cnt,
  output logic [31:0]       miss_cnt,
`endif
  input  logic              mem_ready
);

  localparam int INDEX_W = $clog2(SETS);
  localparam int TAG_W   = ADDR_W - 2 - INDEX_W;

  logic [INDEX_W-1:0] req_idx;
  logic [TAG_W-1:0]   req_tag;
  logic [1:0]         req_word;
  logic               req;

  logic [1:0]         way_valid, way_dirty;
  logic [TAG_W-1:0]   way_tag  [2];
  logic [LINE_W-1:0]  way_line [2];
  logic [1:0]         fill_we, word_we, clean_we;

  logic [1:0]         hit_vec;
  logic               hit, hit_way, victim_sel;
  logic               hit_done, miss_start;

  state_e             state_q, state_d;
  logic               victim_q, victim_d;
  logic [SETS-1:0]    lru_q, lru_d;

  assign req_word   = proc_addr[1:0];
  assign req_idx    = proc_addr[2 +: INDEX_W];
  assign req_tag    = proc_addr[ADDR_W-1 -: TAG_W];
  assign req        = proc_read | proc_write;
  assign hit_vec[0] = way_valid[0] && (way_tag[0] == req_tag);
  assign hit_vec[1] = way_valid[1] && (way_tag[1] == req_tag);
  assign hit        = |hit_vec;
  assign hit_way    = ~hit_vec[0];
  assign victim_sel = !way_valid[0] ? 1'b0 : (!way_valid[1] ? 1'b1 : lru_q[req_idx]);

  dcache_way #(.SETS(SETS), .INDEX_W(INDEX_W), .TAG_W(TAG_W)) u_way0 (
    .clk(clk), .rst_i(proc_reset), .idx_i(req_idx),
    .fill_i(fill_we[0]), .fill_tag_i(req_tag), .fill_data_i(mem_rdata),
    .word_we_i(word_we[0]), .word_i(req_word), .word_data_i(proc_wdata),
    .clean_i(clean_we[0]),
    .valid_o(way_valid[0]), .dirty_o(way_dirty[0]), .tag_o(way_tag[0]), .data_o(way_line[0])
  );

  dcache_way #(.SETS(SETS), .INDEX_W(INDEX_W), .TAG_W(TAG_W)) u_way1 (
    .clk(clk), .rst_i(proc_reset), .idx_i(req_idx),
    .fill_i(fill_we[1]), .fill_tag_i(req_tag), .fill_data_i(mem_rdata),
    .word_we_i(word_we[1]), .word_i(req_word), .word_data_i(proc_wdata),
    .clean_i(clean_we[1]),
    .valid_o(way_valid[1]), .dirty_o(way_dirty[1]), .tag_o(way_tag[1]), .data_o(way_line[1])
  );

  // Controller state, latched victim and per-set LRU; reset abandons any transfer.
  always_ff @(posedge clk) begin
    if (proc_reset) begin
      state_q  <= IDLE;
      victim_q <= 1'b0;
      lru_q    <= '0;
    end else begin
      state_q  <= state_d;
      victim_q <= victim_d;
      lru_q    <= lru_d;
    end
  end

  // Next state, hit handling and memory bus drive; hits complete combinationally.
  always_comb begin
    state_d    = state_q;
    victim_d   = victim_q;
    lru_d      = lru_q;
    proc_stall = 1'b0;
    proc_rdata = '0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;
    fill_we    = '0;
    word_we    = '0;
    clean_we   = '0;
    hit_done   = 1'b0;
    miss_start = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (req) begin
          if (hit) begin
            hit_done       = 1'b1;
            lru_d[req_idx] = ~hit_way;
            if (proc_write) word_we[hit_way] = 1'b1;
            else            proc_rdata       = word_sel(way_line[hit_way], req_word);
          end else begin
            proc_stall = 1'b1;
            miss_start = 1'b1;
            victim_d   = victim_sel;
            state_d    = (way_valid[victim_sel] && way_dirty[victim_sel]) ? WB : ALLOC;
          end
        end
      end
      WB: begin
        proc_stall = 1'b1;
        mem_write  = 1'b1;
        mem_addr   = {way_tag[victim_q], req_idx};
        mem_wdata  = way_line[victim_q];
        if (mem_ready) begin
          clean_we[victim_q] = 1'b1;
          state_d            = ALLOC;
        end
      end
      ALLOC: begin
        proc_stall = 1'b1;
        mem_read   = 1'b1;
        mem_addr   = proc_addr[ADDR_W-1:2];
        if (mem_ready) begin
          fill_we[victim_q] = 1'b1;
          lru_d[req_idx]    = ~victim_q;
          state_d           = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (proc_reset) begin
      fill_we  = '0;
      word_we  = '0;
      clean_we = '0;
    end
  end

`ifdef DCACHE_STATS_EN
  logic [31:0] hit_cnt_q, miss_cnt_q;
  logic        refill_q;

  // Counters: a completion right after a refill belongs to the miss, not a hit.
  always_ff @(posedge clk) begin
    if (proc_reset) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
      refill_q   <= 1'b0;
    end else begin
      refill_q <= |fill_we;
      if (miss_start)             miss_cnt_q <= miss_cnt_q + 32'd1;
      if (hit_done && !refill_q)  hit_cnt_q  <= hit_cnt_q + 32'd1;
    end
  end

  assign hit_cnt  = hit_cnt_q;
  assign miss_cnt = miss_cnt_q;
`endif

endmodule

// File: tb/tb_dcache_2way_wb.sv
// Testbench for dcache_2way_wb. The bench plays main memory and keeps a
// flat word-level golden memory plus a tag/LRU occupancy model to predict
// hits, victims and write-backs. Counter checks run when DCACHE_STATS_EN is defined.
module tb_dcache_2way_wb;

  localparam int ADDR_W = 30;
  localparam int SETS   = 4;

  logic         clk = 1'b0;
  logic         proc_reset, proc_read, proc_write;
  logic [29:0]  proc_addr;
  logic [31:0]  proc_wdata;
  logic         proc_stall;
  logic [31:0]  proc_rdata;
  logic         mem_read, mem_write, mem_ready;
  logic [27:0]  mem_addr;
  logic [127:0] mem_wdata, mem_rdata;
`ifdef DCACHE_STATS_EN
  logic [31:0]  hit_cnt, miss_cnt;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  dcache_2way_wb #(.ADDR_W(ADDR_W), .SETS(SETS)) dut (
    .clk(clk), .proc_reset(proc_reset), .proc_read(proc_read), .proc_write(proc_write),
    .proc_addr(proc_addr), .proc_wdata(proc_wdata), .proc_stall(proc_stall),
    .proc_rdata(proc_rdata), .mem_read(mem_read), .mem_write(mem_write),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
`ifdef DCACHE_STATS_EN
    .hit_cnt(hit_cnt), .miss_cnt(miss_cnt),
`endif
    .mem_ready(mem_ready)
  );

  // Backing memory (line granular) and golden processor-visible words.
  logic [127:0] memLines  [logic [27:0]];
  logic [31:0]  goldWords [logic [29:0]];

  function automatic logic [127:0] initLine(input logic [27:0] la);
    logic [127:0] l;
    for (int i = 0; i < 4; i++) l[32*i +: 32] = {2'(i), la, 2'b10};
    return l;
  endfunction

  function automatic logic [127:0] memLine(input logic [27:0] la);
    if (memLines.exists(la)) return memLines[la];
    return initLine(la);
  endfunction

  function automatic logic [31:0] goldWord(input logic [29:0] a);
    logic [127:0] l;
    if (goldWords.exists(a)) return goldWords[a];
    l = memLine(a[29:2]);
    return l[32*a[1:0] +: 32];
  endfunction

  function automatic logic [127:0] goldLine(input logic [27:0] la);
    logic [127:0] l;
    for (int i = 0; i < 4; i++) l[32*i +: 32] = goldWord({la, 2'(i)});
    return l;
  endfunction

  // Occupancy model: which tags sit in which way, dirtiness and LRU per set.
  bit          mValid [SETS][2];
  bit          mDirty [SETS][2];
  logic [25:0] mTag   [SETS][2];
  bit          mLru   [SETS];
  bit          pHit, pWb;
  logic [27:0] pWbAddr;

  task automatic modelReset();
    for (int s = 0; s < SETS; s++) begin
      mLru[s] = 0;
      for (int k = 0; k < 2; k++) begin mValid[s][k] = 0; mDirty[s][k] = 0; end
    end
    goldWords.delete();
  endtask

  task automatic modelAccess(input logic [29:0] a, input bit isWrite);
    int s;
    int way;
    logic [25:0] t;
    s = int'(a[3:2]);
    t = a[29:4];
    way = 0;
    pHit = 0; pWb = 0; pWbAddr = '0;
    for (int k = 0; k < 2; k++) if (mValid[s][k] && mTag[s][k] == t) begin pHit = 1; way = k; end
    if (!pHit) begin
      if (!mValid[s][0])      way = 0;
      else if (!mValid[s][1]) way = 1;
      else                    way = mLru[s] ? 1 : 0;
      if (mValid[s][way] && mDirty[s][way]) begin
        pWb = 1;
        pWbAddr = {mTag[s][way], 2'(s)};
      end
      mValid[s][way] = 1; mTag[s][way] = t; mDirty[s][way] = 0;
    end
    mLru[s] = (way == 0);
    if (isWrite) mDirty[s][way] = 1;
  endtask

  // Observations from one processor access, filled in by access().
  logic [31:0]  oRdata;
  int           oStalls, oWbCyc, oRdCyc;
  bit           oWb, oRd, oBoth, oIdleBad, oTimeout;
  logic [27:0]  oWbAddr, oRdAddr;
  logic [127:0] oWbData;

  // Holds a request until it completes, acting as memory with random latency.
  task automatic access(input bit rd, input bit wr, input logic [29:0] a,
                        input logic [31:0] wd, input int maxLat);
    int  waitN;
    bit  done;
    done = 0;
    oStalls = 0; oWb = 0; oRd = 0; oBoth = 0; oIdleBad = 0; oTimeout = 0;
    oWbCyc = -1; oRdCyc = -1; oRdata = '0; oWbAddr = '0; oRdAddr = '0; oWbData = '0;
    proc_read = rd; proc_write = wr; proc_addr = a; proc_wdata = wd;
    waitN = $urandom_range(0, maxLat);
    for (int cyc = 0; cyc < 40 && !done; cyc++) begin
      @(negedge clk);
      mem_ready = 1'b0;
      if (mem_read && mem_write) oBoth = 1;
      if (!mem_read && !mem_write && (mem_addr !== '0 || mem_wdata !== '0)) oIdleBad = 1;
      if (!proc_stall) begin
        oRdata = proc_rdata;
        done = 1;
      end else begin
        oStalls++;
        if (mem_read || mem_write) begin
          if (waitN > 0) waitN--;
          else begin
            if (mem_write) begin
              oWb = 1; oWbCyc = cyc; oWbAddr = mem_addr; oWbData = mem_wdata;
              memLines[mem_addr] = mem_wdata;
            end else begin
              oRd = 1; oRdCyc = cyc; oRdAddr = mem_addr;
              mem_rdata = memLine(mem_addr);
            end
            mem_ready = 1'b1;
            waitN = $urandom_range(0, maxLat);
          end
        end
      end
    end
    if (!done) oTimeout = 1;
    @(posedge clk);
    #1;
    proc_read = 1'b0; proc_write = 1'b0; mem_ready = 1'b0;
    if (done && wr) goldWords[a] = wd;
  endtask

  task automatic resetDut();
    proc_reset = 1'b1; proc_read = 1'b0; proc_write = 1'b0; mem_ready = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    proc_reset = 1'b0;
    modelReset();
  endtask

  task automatic test_reset();
    resetDut();
    @(negedge clk);
    total++; if (proc_stall !== 1'b0) begin bad++; $display("[TB] FAIL reset_stall: got %b want 0", proc_stall); end
    total++; if (proc_rdata !== 32'h0) begin bad++; $display("[TB] FAIL reset_rdata: got %h want 0", proc_rdata); end
    total++; if ({mem_read, mem_write} !== 2'b00) begin bad++; $display("[TB] FAIL reset_memctl: got %b want 00", {mem_read, mem_write}); end
    total++; if (mem_addr !== '0 || mem_wdata !== '0) begin bad++; $display("[TB] FAIL reset_membus: got addr %h data %h want 0", mem_addr, mem_wdata); end
`ifdef DCACHE_STATS_EN
    total++; if (hit_cnt !== 0 || miss_cnt !== 0) begin bad++; $display("[TB] FAIL reset_counters: got %0d/%0d want 0/0", hit_cnt, miss_cnt); end
`endif
    @(posedge clk); #1;
  endtask

  task automatic test_read_miss();
    memLines[28'h4] = 128'hDDDDDDDD_CCCCCCCC_BBBBBBBB_AAAAAAAA;
    modelAccess(30'h10, 0);
    access(1, 0, 30'h10, 32'h0, 0);
    total++; if (oRd !== 1'b1 || oRdAddr !== 28'h4) begin bad++; $display("[TB] FAIL miss_fetch: got rd=%b addr=%h want rd=1 addr=4", oRd, oRdAddr); end
    total++; if (oWb !== 1'b0) begin bad++; $display("[TB] FAIL miss_nowb: got %b want 0", oWb); end
    total++; if (oStalls != 2) begin bad++; $display("[TB] FAIL miss_latency: got %0d want 2", oStalls); end
    total++; if (oRdata !== 32'hAAAAAAAA) begin bad++; $display("[TB] FAIL miss_data: got %h want aaaaaaaa", oRdata); end
  endtask

  task automatic test_write_hit();
    modelAccess(30'h11, 1);
    access(0, 1, 30'h11, 32'h12345678, 2);
    total++; if (oStalls != 0) begin bad++; $display("[TB] FAIL wrhit_stall: got %0d want 0", oStalls); end
    modelAccess(30'h11, 0);
    access(1, 0, 30'h11, 32'h0, 2);
    total++; if (oStalls != 0 || oRdata !== 32'h12345678) begin bad++; $display("[TB] FAIL wrhit_readback: got %h stalls %0d want 12345678 stalls 0", oRdata, oStalls); end
  endtask

  task automatic test_eviction();
    logic [127:0] expLine;
    modelAccess(30'h20, 0); access(1, 0, 30'h20, 32'h0, 1);
    modelAccess(30'h21, 1); access(0, 1, 30'h21, 32'h5A5A0021, 1);
    modelAccess(30'h10, 0); access(1, 0, 30'h10, 32'h0, 1);
    expLine = goldLine(28'h8);
    modelAccess(30'h30, 0); access(1, 0, 30'h30, 32'h0, 1);
    total++; if (oWb !== 1'b1 || oWbAddr !== 28'h8) begin bad++; $display("[TB] FAIL evict_wbaddr: got wb=%b addr=%h want wb=1 addr=8", oWb, oWbAddr); end
    total++; if (oWbData !== expLine) begin bad++; $display("[TB] FAIL evict_wbdata: got %h want %h", oWbData, expLine); end
    total++; if (oRdAddr !== 28'hC || oWbCyc < 0 || oRdCyc <= oWbCyc) begin bad++; $display("[TB] FAIL evict_order: got rdaddr=%h wbcyc=%0d rdcyc=%0d want rdaddr=c after wb", oRdAddr, oWbCyc, oRdCyc); end
    total++; if (oRdata !== goldWord(30'h30)) begin bad++; $display("[TB] FAIL evict_data: got %h want %h", oRdata, goldWord(30'h30)); end
    modelAccess(30'h11, 0); access(1, 0, 30'h11, 32'h0, 1);
    total++; if (oStalls != 0 || oRdata !== 32'h12345678) begin bad++; $display("[TB] FAIL evict_keptway0: got %h stalls %0d want 12345678 stalls 0", oRdata, oStalls); end
  endtask

  task automatic test_reset_in_alloc();
    bit seen;
    seen = 0;
    proc_read = 1'b1; proc_write = 1'b0; proc_addr = 30'h40;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clk);
      if (mem_read) seen = 1;
    end
    total++; if (!seen) begin bad++; $display("[TB] FAIL rstalloc_reach: got mem_read=0 want 1"); end
    proc_reset = 1'b1; proc_read = 1'b0;
    @(posedge clk); #1;
    proc_reset = 1'b0;
    modelReset();
    @(negedge clk);
    total++; if (mem_read !== 1'b0 || proc_stall !== 1'b0) begin bad++; $display("[TB] FAIL rstalloc_idle: got mem_read=%b stall=%b want 0 0", mem_read, proc_stall); end
    @(posedge clk); #1;
    modelAccess(30'h10, 0); access(1, 0, 30'h10, 32'h0, 1);
    total++; if (oRd !== 1'b1 || oStalls == 0) begin bad++; $display("[TB] FAIL rstalloc_remiss: got rd=%b stalls=%0d want a miss", oRd, oStalls); end
    modelAccess(30'h11, 0); access(1, 0, 30'h11, 32'h0, 1);
    total++; if (oRdata !== 32'hBBBBBBBB) begin bad++; $display("[TB] FAIL rstalloc_discard: got %h want bbbbbbbb", oRdata); end
  endtask

  task automatic test_rw_same();
    modelAccess(30'h12, 1);
    access(1, 1, 30'h12, 32'hCAFEF00D, 1);
    total++; if (oStalls != 0 || oRdata !== 32'h0) begin bad++; $display("[TB] FAIL rw_rdata: got %h stalls %0d want 0 stalls 0", oRdata, oStalls); end
    modelAccess(30'h12, 0);
    access(1, 0, 30'h12, 32'h0, 1);
    total++; if (oRdata !== 32'hCAFEF00D) begin bad++; $display("[TB] FAIL rw_written: got %h want cafef00d", oRdata); end
  endtask

  task automatic test_random();
    logic [29:0]  a;
    logic [31:0]  wd, expData;
    logic [127:0] expWb;
    int           op;
    bit           rd, wr;
    for (int n = 0; n < 120; n++) begin
      a  = {26'($urandom_range(0, 5)), 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3))};
      op = $urandom_range(0, 2);
      rd = (op != 1);
      wr = (op != 0);
      wd = $urandom;
      expData = wr ? 32'h0 : goldWord(a);
      modelAccess(a, wr);
      expWb = pWb ? goldLine(pWbAddr) : '0;
      access(rd, wr, a, wd, 2);
      total++; if (oTimeout) begin bad++; $display("[TB] FAIL rnd_timeout: addr %h got no completion want completion", a); end
      total++; if ((oStalls == 0) !== pHit) begin bad++; $display("[TB] FAIL rnd_hit: addr %h got hit=%b want %b", a, (oStalls == 0), pHit); end
      total++; if (oRdata !== expData) begin bad++; $display("[TB] FAIL rnd_rdata: addr %h got %h want %h", a, oRdata, expData); end
      total++; if (oWb !== pWb || (pWb && (oWbAddr !== pWbAddr || oWbData !== expWb))) begin
        bad++; $display("[TB] FAIL rnd_wb: addr %h got wb=%b %h want wb=%b %h", a, oWb, oWbAddr, pWb, pWbAddr);
      end
      total++; if (oRd !== !pHit || (!pHit && oRdAddr !== a[29:2])) begin bad++; $display("[TB] FAIL rnd_fetch: addr %h got rd=%b %h want rd=%b", a, oRd, oRdAddr, !pHit); end
      total++; if (oBoth || oIdleBad) begin bad++; $display("[TB] FAIL rnd_bus: got both=%b idlebus=%b want 0 0", oBoth, oIdleBad); end
    end
  endtask

`ifdef DCACHE_STATS_EN
  task automatic test_stats();
    resetDut();
    modelAccess(30'h10, 0); access(1, 0, 30'h10, 32'h0, 1);
    modelAccess(30'h20, 0); access(1, 0, 30'h20, 32'h0, 1);
    modelAccess(30'h11, 0); access(1, 0, 30'h11, 32'h0, 1);
    modelAccess(30'h21, 1); access(0, 1, 30'h21, 32'h77, 1);
    modelAccess(30'h12, 0); access(1, 0, 30'h12, 32'h0, 1);
    total++; if (hit_cnt !== 32'd3) begin bad++; $display("[TB] FAIL stats_hits: got %0d want 3", hit_cnt); end
    total++; if (miss_cnt !== 32'd2) begin bad++; $display("[TB] FAIL stats_misses: got %0d want 2", miss_cnt); end
  endtask
`endif

  // Bound the whole run in case the design wedges somewhere unexpected.
  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: got no finish want finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Scenario sequence followed by the summary line.
  initial begin
    proc_reset = 1'b1; proc_read = 1'b0; proc_write = 1'b0;
    proc_addr = '0; proc_wdata = '0; mem_ready = 1'b0; mem_rdata = '0;
    test_reset();
    test_read_miss();
    test_write_hit();
    test_eviction();
    test_reset_in_alloc();
    test_rw_same();
    test_random();
`ifdef DCACHE_STATS_EN
    test_stats();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
